// File: rtl/mapping_group_accum_if.sv
// Valid/ready beat and result bus of one PIM mapping-group accumulator.
interface mapping_group_accum_if #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned ENC_W    = 7,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned IN_STEPS = 4
);
  localparam int unsigned STEP_W = $clog2(IN_STEPS + 1);

  logic                   mode;
  logic                   clear;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_CH*ENC_W-1:0]  enc;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic [STEP_W-1:0]      step;
  logic                   busy;

  modport master (
    output mode, clear, in_valid, enc, out_ready,
    input  in_ready, out_valid, out_data, step, busy
  );

  modport slave (
    input  mode, clear, in_valid, enc, out_ready,
    output in_ready, out_valid, out_data, step, busy
  );
endinterface

// File: rtl/mapping_group_accum.sv
// Bit-serial shift-and-accumulate engine: weights channels by cell position and
// either emits the beat sum (PARALLEL) or accumulates it over input-bit steps (RBR).
module mapping_group_accum #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned ENC_W      = 7,
  parameter int unsigned CELL_BITS  = 2,
  parameter int unsigned IN_STEPS   = 4,
  parameter int unsigned STEP_SHIFT = 2,
  parameter int unsigned SIGNED_MSB = 0,
  parameter int unsigned OUT_W      = 32
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  mapping_group_accum_if.slave  bus
);
  localparam int unsigned SUM_W  = ENC_W + CELL_BITS * (N_CH - 1) + 1;
  localparam int unsigned ACC_W  = SUM_W + STEP_SHIFT * (IN_STEPS - 1) + 1;
  localparam int unsigned STEP_W = $clog2(IN_STEPS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(IN_STEPS - 1);
  localparam logic [STEP_W-1:0] ONE_STEP  = STEP_W'(1);

  logic [1:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              out_valid_q, busy_q;
  logic [ACC_W-1:0]  sum_c, term_c;
  logic              in_ready_c, accept_c, pop_c;

  // Channel 0 sits in the MSBs of enc and carries the largest cell weight.
  always_comb begin
    sum_c = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      sum_c = sum_c + (ACC_W'(bus.enc[(N_CH - 1 - c) * ENC_W +: ENC_W])
                       << (CELL_BITS * (N_CH - 1 - c)));
    end
  end

  assign term_c     = sum_c << (STEP_SHIFT * 32'(step_q));
  assign in_ready_c = (state_q != S_OUT) | bus.out_ready;
  assign accept_c   = bus.in_valid & in_ready_c;
  assign pop_c      = out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    step_d  = step_q;
    if (bus.clear) begin
      state_d = S_IDLE;
      acc_d   = '0;
      step_d  = '0;
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (accept_c) begin
            if (step_q == LAST_STEP) begin
              acc_d   = (SIGNED_MSB != 0) ? acc_q - term_c : acc_q + term_c;
              state_d = S_OUT;
            end else begin
              acc_d = acc_q + term_c;
            end
            step_d = step_q + ONE_STEP;
          end
        end
        default: begin
          // IDLE and OUT: a pop retires the result, and a beat in the same cycle starts the next group.
          if (pop_c) begin
            state_d = S_IDLE;
            step_d  = '0;
          end
          if (accept_c) begin
            if (!bus.mode || IN_STEPS == 1) begin
              acc_d   = (bus.mode && SIGNED_MSB != 0) ? ACC_W'(0) - sum_c : sum_c;
              state_d = S_OUT;
            end else begin
              acc_d   = sum_c;
              state_d = S_ACCUM;
            end
            step_d = ONE_STEP;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      step_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      out_valid_q <= (state_d == S_OUT);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.step      = step_q;
  assign bus.busy      = busy_q;

  if (SIGNED_MSB != 0) begin : g_sext
    assign bus.out_data = OUT_W'($signed(acc_q));
  end else begin : g_zext
    assign bus.out_data = OUT_W'(acc_q);
  end
endmodule
